// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the MIPS register file and the blocks around it
// (decode, ALU, board debug).
package regfile_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int ZERO_REG       = 0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Each register comes out of reset holding its own index, so a board display
   // can show that the scanner is working before any program runs.
   function automatic int reg_reset_value(input int idx);
      return idx;
   endfunction

endpackage

// File: rtl/regfile_param_push_sync_edge.sv
// Button conditioner: 2-flop synchroniser and rising-edge detector.
// The output is a one-cycle pulse for each press.
module push_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic vld1_q, vld1_d;
   logic vld2_q, vld2_d;
   logic hist_q, hist_d;

   // Until the chain has refilled after reset, history is held high.
   // This stops a button held through reset from producing a pulse.
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      vld1_d  = 1'b1;
      vld2_d  = vld1_q;
      hist_d  = vld2_q ? sync2_q : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         vld1_q  <= 1'b0;
         vld2_q  <= 1'b0;
         hist_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         vld1_q  <= vld1_d;
         vld2_q  <= vld2_d;
         hist_q  <= hist_d;
      end
   end

   assign pulse = vld2_q & sync2_q & ~hist_q;

endmodule

// File: rtl/regfile_param.sv
// MIPS general-purpose register file: r0 is hardwired to zero.
// Two registered read ports with write-through bypass, plus a push-button debug scanner.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NREGS  = 8,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DBG_W  = 8,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              push,
   output logic [DBG_W-1:0]  dbg_data,
   output logic [IDX_W-1:0]  dbg_index
);

   localparam int PTR_W = (clog2(NREGS) < 1) ? 1 : clog2(NREGS);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
   logic [DBG_W-1:0]  dbg_data_q, dbg_data_d;
   logic [IDX_W-1:0]  dbg_index_q, dbg_index_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              wr_ok;
   logic              push_pulse;

   push_sync_edge u_push (
      .clk   (clk),
      .reset (reset),
      .din   (push),
      .pulse (push_pulse)
   );

   // Out-of-range and r0 writes are dropped here, so they can neither update state nor bypass.
   always_comb begin
      wr_ok = we && (waddr != '0) && ({1'b0, waddr} < (ADDR_W + 1)'(NREGS));
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_ok && (waddr == ADDR_W'(i))) regs_d[i] = wdata;
      end
      regs_d[ZERO_REG] = '0;
   end

   always_comb begin
      rdata_a_d  = '0;
      rdata_b_d  = '0;
      dbg_data_d = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (raddr_a == ADDR_W'(i)) rdata_a_d = regs_q[i];
         if (raddr_b == ADDR_W'(i)) rdata_b_d = regs_q[i];
         if (ptr_q == PTR_W'(i))    dbg_data_d = regs_q[i][DBG_W-1:0];
      end
      if (wr_ok && (raddr_a == waddr)) rdata_a_d = wdata;
      if (wr_ok && (raddr_b == waddr)) rdata_b_d = wdata;
      ptr_d = ptr_q;
      if (push_pulse) ptr_d = (ptr_q == PTR_W'(NREGS - 1)) ? '0 : ptr_q + PTR_W'(1);
      dbg_index_d = IDX_W'(ptr_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(reg_reset_value(i));
         rdata_a_q   <= '0;
         rdata_b_q   <= '0;
         dbg_data_q  <= '0;
         dbg_index_q <= '0;
         ptr_q       <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
         rdata_a_q   <= rdata_a_d;
         rdata_b_q   <= rdata_b_d;
         dbg_data_q  <= dbg_data_d;
         dbg_index_q <= dbg_index_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rdata_a   = rdata_a_q;
   assign rdata_b   = rdata_b_q;
   assign dbg_data  = dbg_data_q;
   assign dbg_index = dbg_index_q;

endmodule
